sap1_control_sequencer: RTL and testbench

//  Fetch/execute controller for the SAP-1 datapath (PC, MAR, RAM, IR, A, B, ALU, OUT registers).
//  A one-hot T-state ring counter is decoded with the IR opcode into per-cycle load/drive

---
 rtl/sap1_pkg.sv | 33 +++
 rtl/sap1_ring_counter.sv | 34 +++
 rtl/sap1_control_sequencer.sv | 132 +++++++++++++
 tb/tb_sap1_control_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 control sequencer: opcodes, one-hot T-states and control-word layout.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    localparam int CTRL_WIDTH = 12;
    localparam int CW_PC_INC  = 0;
    localparam int CW_PC_OUT  = 1;
    localparam int CW_MAR_IN  = 2;
    localparam int CW_RAM_OUT = 3;
    localparam int CW_IR_IN   = 4;
    localparam int CW_IR_OUT  = 5;
    localparam int CW_A_IN    = 6;
    localparam int CW_A_OUT   = 7;
    localparam int CW_B_IN    = 8;
    localparam int CW_SUM_OUT = 9;
    localparam int CW_SUB     = 10;
    localparam int CW_OUT_IN  = 11;

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot T-state ring: rotates each clock unless held; load_t1 forces an early return to T1.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       hold,
    input  logic       load_t1,
    output logic [5:0] state
);

    tstate_e state_q;
    tstate_e state_d;

    always_comb begin
        state_d = state_q;
        if (load_t1) begin
            state_d = T1;
        end else if (!hold) begin
            state_d = tstate_e'({state_q[4:0], state_q[5]});
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 fetch/execute controller: decodes T-state and opcode into datapath enables, with run gate and HLT.
// Optional macro SAP1_VARIABLE_CYCLE_EN shortens LDA/OUT/NOP by returning to T1 early.
module sap1_control_sequencer
    import sap1_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    run,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [5:0]              tstate,
    output logic                    pc_inc,
    output logic                    pc_out,
    output logic                    mar_in,
    output logic                    ram_out,
    output logic                    ir_in,
    output logic                    ir_out,
    output logic                    a_in,
    output logic                    a_out,
    output logic                    b_in,
    output logic                    sum_out,
    output logic                    sub,
    output logic                    out_in,
    output logic                    halted
);

    logic                  halted_q;
    logic                  advance;
    logic                  hlt_stop;
    logic                  hold;
    logic                  load_t1;
    logic                  is_lda, is_add, is_sub, is_out, is_hlt;
    logic [CTRL_WIDTH-1:0] ctrl;

    // Zero-extended compares make any nonzero upper opcode bit fall through to NOP.
    assign is_lda = (opcode == OPCODE_WIDTH'(OP_LDA));
    assign is_add = (opcode == OPCODE_WIDTH'(OP_ADD));
    assign is_sub = (opcode == OPCODE_WIDTH'(OP_SUB));
    assign is_out = (opcode == OPCODE_WIDTH'(OP_OUT));
    assign is_hlt = (opcode == OPCODE_WIDTH'(OP_HLT));

    assign advance  = run && !halted_q;
    assign hlt_stop = advance && (tstate == T4) && is_hlt;
    assign hold     = !advance || hlt_stop;

`ifdef SAP1_VARIABLE_CYCLE_EN
    assign load_t1 = advance &&
                     (((tstate == T5) && is_lda) ||
                      ((tstate == T4) && !(is_lda || is_add || is_sub || is_hlt)));
`else
    assign load_t1 = 1'b0;
`endif

    sap1_ring_counter u_ring (
        .clock   (clock),
        .reset   (reset),
        .hold    (hold),
        .load_t1 (load_t1),
        .state   (tstate)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else if (hlt_stop) begin
            halted_q <= 1'b1;
        end
    end

    always_comb begin
        ctrl = '0;
        if (!reset && advance) begin
            case (tstate)
                T1: begin
                    ctrl[CW_PC_OUT] = 1'b1;
                    ctrl[CW_MAR_IN] = 1'b1;
                end
                T2: ctrl[CW_PC_INC] = 1'b1;
                T3: begin
                    ctrl[CW_RAM_OUT] = 1'b1;
                    ctrl[CW_IR_IN]   = 1'b1;
                end
                T4: begin
                    if (is_lda || is_add || is_sub) begin
                        ctrl[CW_IR_OUT] = 1'b1;
                        ctrl[CW_MAR_IN] = 1'b1;
                    end else if (is_out) begin
                        ctrl[CW_A_OUT]  = 1'b1;
                        ctrl[CW_OUT_IN] = 1'b1;
                    end
                end
                T5: begin
                    if (is_lda) begin
                        ctrl[CW_RAM_OUT] = 1'b1;
                        ctrl[CW_A_IN]    = 1'b1;
                    end else if (is_add || is_sub) begin
                        ctrl[CW_RAM_OUT] = 1'b1;
                        ctrl[CW_B_IN]    = 1'b1;
                    end
                end
                T6: begin
                    if (is_add || is_sub) begin
                        ctrl[CW_SUM_OUT] = 1'b1;
                        ctrl[CW_A_IN]    = 1'b1;
                        ctrl[CW_SUB]     = is_sub;
                    end
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign pc_inc  = ctrl[CW_PC_INC];
    assign pc_out  = ctrl[CW_PC_OUT];
    assign mar_in  = ctrl[CW_MAR_IN];
    assign ram_out = ctrl[CW_RAM_OUT];
    assign ir_in   = ctrl[CW_IR_IN];
    assign ir_out  = ctrl[CW_IR_OUT];
    assign a_in    = ctrl[CW_A_IN];
    assign a_out   = ctrl[CW_A_OUT];
    assign b_in    = ctrl[CW_B_IN];
    assign sum_out = ctrl[CW_SUM_OUT];
    assign sub     = ctrl[CW_SUB];
    assign out_in  = ctrl[CW_OUT_IN];
    assign halted  = halted_q;

    // Only one register may drive the shared bus in any cycle.
    bus_single_driver : assert property (@(posedge clock)
        $onehot0({pc_out, ram_out, ir_out, a_out, sum_out}));

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Directed bench for sap1_control_sequencer: per-cycle expectations queued by the driver, checked by a monitor.
module tb_sap1_control_sequencer;

    logic       clock;
    logic       reset;
    logic       run;
    logic [3:0] opcode;
    logic [5:0] tstate;
    logic       pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out;
    logic       a_in, a_out, b_in, sum_out, sub, out_in;
    logic       halted;

    localparam logic [11:0] E_NONE    = 12'h000;
    localparam logic [11:0] E_PC_INC  = 12'h800;
    localparam logic [11:0] E_PC_OUT  = 12'h400;
    localparam logic [11:0] E_MAR_IN  = 12'h200;
    localparam logic [11:0] E_RAM_OUT = 12'h100;
    localparam logic [11:0] E_IR_IN   = 12'h080;
    localparam logic [11:0] E_IR_OUT  = 12'h040;
    localparam logic [11:0] E_A_IN    = 12'h020;
    localparam logic [11:0] E_A_OUT   = 12'h010;
    localparam logic [11:0] E_B_IN    = 12'h008;
    localparam logic [11:0] E_SUM_OUT = 12'h004;
    localparam logic [11:0] E_SUB     = 12'h002;
    localparam logic [11:0] E_OUT_IN  = 12'h001;

    localparam logic [5:0] S1 = 6'b000001;
    localparam logic [5:0] S2 = 6'b000010;
    localparam logic [5:0] S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000;
    localparam logic [5:0] S5 = 6'b010000;
    localparam logic [5:0] S6 = 6'b100000;

    logic [18:0] exp_q[$];
    string       name_q[$];
    int          checks   = 0;
    int          failures = 0;

    sap1_control_sequencer #(.OPCODE_WIDTH(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .opcode  (opcode),
        .tstate  (tstate),
        .pc_inc  (pc_inc),
        .pc_out  (pc_out),
        .mar_in  (mar_in),
        .ram_out (ram_out),
        .ir_in   (ir_in),
        .ir_out  (ir_out),
        .a_in    (a_in),
        .a_out   (a_out),
        .b_in    (b_in),
        .sum_out (sum_out),
        .sub     (sub),
        .out_in  (out_in),
        .halted  (halted)
    );

    // clock / reset
    initial begin
        clock  = 1'b0;
        reset  = 1'b1;
        run    = 1'b0;
        opcode = 4'h0;
        forever #5 clock = ~clock;
    end

    // Driver: inputs for the coming cycle plus the outputs expected during it.
    task automatic step(input logic r, input logic rn, input logic [3:0] op,
                        input logic [5:0] et, input logic [11:0] ec, input logic eh,
                        input string nm);
        @(posedge clock);
        #1;
        reset  = r;
        run    = rn;
        opcode = op;
        exp_q.push_back({eh, et, ec});
        name_q.push_back(nm);
    endtask

    function automatic int ilen(input logic [3:0] op);
`ifdef SAP1_VARIABLE_CYCLE_EN
        if (op == 4'h0) return 5;
        if (op == 4'h1 || op == 4'h2) return 6;
        return 4;
`else
        return 6;
`endif
    endfunction

    task automatic instr(input logic [3:0] op, input logic [11:0] c4, input logic [11:0] c5,
                         input logic [11:0] c6, input string nm);
        int n;
        n = ilen(op);
        step(1'b0, 1'b1, op, S1, E_PC_OUT | E_MAR_IN, 1'b0, {nm, "_t1"});
        step(1'b0, 1'b1, op, S2, E_PC_INC, 1'b0, {nm, "_t2"});
        step(1'b0, 1'b1, op, S3, E_RAM_OUT | E_IR_IN, 1'b0, {nm, "_t3"});
        step(1'b0, 1'b1, op, S4, c4, 1'b0, {nm, "_t4"});
        if (n >= 5) step(1'b0, 1'b1, op, S5, c5, 1'b0, {nm, "_t5"});
        if (n >= 6) step(1'b0, 1'b1, op, S6, c6, 1'b0, {nm, "_t6"});
    endtask

    // Scoreboard monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clock) begin
        logic [18:0] act;
        logic [18:0] exp_v;
        string       nm;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act   = {halted, tstate, pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out,
                     a_in, a_out, b_in, sum_out, sub, out_in};
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL %s: got halted=%b tstate=%b ctrl=%h, expected halted=%b tstate=%b ctrl=%h",
                         nm, act[18], act[17:12], act[11:0], exp_v[18], exp_v[17:12], exp_v[11:0]);
            end
        end
    end

    initial begin
        // reset held three clocks
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, S1, E_NONE, 1'b0, "reset_hold");
        // paused at T1: no enables, no advance
        step(1'b0, 1'b0, 4'h0, S1, E_NONE, 1'b0, "pause_t1_a");
        step(1'b0, 1'b0, 4'h0, S1, E_NONE, 1'b0, "pause_t1_b");

        instr(4'h1, E_IR_OUT | E_MAR_IN, E_RAM_OUT | E_B_IN, E_SUM_OUT | E_A_IN, "add");
        instr(4'h2, E_IR_OUT | E_MAR_IN, E_RAM_OUT | E_B_IN, E_SUM_OUT | E_A_IN | E_SUB, "sub");

        // LDA paused at T5 for four clocks, then resumes with exactly one load pulse
        step(1'b0, 1'b1, 4'h0, S1, E_PC_OUT | E_MAR_IN, 1'b0, "lda_p_t1");
        step(1'b0, 1'b1, 4'h0, S2, E_PC_INC, 1'b0, "lda_p_t2");
        step(1'b0, 1'b1, 4'h0, S3, E_RAM_OUT | E_IR_IN, 1'b0, "lda_p_t3");
        step(1'b0, 1'b1, 4'h0, S4, E_IR_OUT | E_MAR_IN, 1'b0, "lda_p_t4");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, S5, E_NONE, 1'b0, "lda_paused_t5");
        step(1'b0, 1'b1, 4'h0, S5, E_RAM_OUT | E_A_IN, 1'b0, "lda_resume_t5");
`ifndef SAP1_VARIABLE_CYCLE_EN
        step(1'b0, 1'b1, 4'h0, S6, E_NONE, 1'b0, "lda_resume_t6");
`endif

        // reset at T5 of ADD aborts it without the b_in pulse
        step(1'b0, 1'b1, 4'h1, S1, E_PC_OUT | E_MAR_IN, 1'b0, "addr_t1");
        step(1'b0, 1'b1, 4'h1, S2, E_PC_INC, 1'b0, "addr_t2");
        step(1'b0, 1'b1, 4'h1, S3, E_RAM_OUT | E_IR_IN, 1'b0, "addr_t3");
        step(1'b0, 1'b1, 4'h1, S4, E_IR_OUT | E_MAR_IN, 1'b0, "addr_t4");
        step(1'b1, 1'b1, 4'h1, S5, E_NONE, 1'b0, "addr_reset_t5");

        // NOP opcode 7, then LDA/OUT/ADD stream
        instr(4'h7, E_NONE, E_NONE, E_NONE, "nop7");
        instr(4'h0, E_IR_OUT | E_MAR_IN, E_RAM_OUT | E_A_IN, E_NONE, "s_lda");
        instr(4'hE, E_A_OUT | E_OUT_IN, E_NONE, E_NONE, "s_out");
        instr(4'h1, E_IR_OUT | E_MAR_IN, E_RAM_OUT | E_B_IN, E_SUM_OUT | E_A_IN, "s_add");

        // HLT: sticks at T4 until reset
        step(1'b0, 1'b1, 4'hF, S1, E_PC_OUT | E_MAR_IN, 1'b0, "hlt_t1");
        step(1'b0, 1'b1, 4'hF, S2, E_PC_INC, 1'b0, "hlt_t2");
        step(1'b0, 1'b1, 4'hF, S3, E_RAM_OUT | E_IR_IN, 1'b0, "hlt_t3");
        step(1'b0, 1'b1, 4'hF, S4, E_NONE, 1'b0, "hlt_t4");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'hF, S4, E_NONE, 1'b1, "halted_hold");
        step(1'b0, 1'b1, 4'h1, S4, E_NONE, 1'b1, "halted_other_op");
        step(1'b1, 1'b1, 4'h1, S4, E_NONE, 1'b1, "halted_reset_cycle");
        step(1'b0, 1'b1, 4'h1, S1, E_PC_OUT | E_MAR_IN, 1'b0, "after_halt_t1");
        step(1'b0, 1'b1, 4'h1, S2, E_PC_INC, 1'b0, "after_halt_t2");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clock);
        @(posedge clock);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
